// File: rtl/cmp_share_pkg.sv
// Shared types and constants for the shared-comparator arbiter (cmp_share_arb).
package cmp_share_pkg;

  localparam int CMP_DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational DATA_W magnitude comparator producing a one-hot eq/gt/lt result.
// Build option: define CMP_SIGNED_EN for two's-complement compare (default unsigned).
module cmp_core
  import cmp_share_pkg::*;
#(
  parameter int DATA_W = CMP_DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output cmp_res_t          res_o
);

  always_comb begin
    res_o    = '0;
    res_o.eq = (a_i == b_i);
`ifdef CMP_SIGNED_EN
    res_o.gt = ($signed(a_i) > $signed(b_i));
    res_o.lt = ($signed(a_i) < $signed(b_i));
`else
    res_o.gt = (a_i > b_i);
    res_o.lt = (a_i < b_i);
`endif
  end

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one registered comparator among NUM_REQ requesters.
// Compare signedness selected by CMP_SIGNED_EN inside cmp_core.
//
// state | meaning
// IDLE  | arbitrating; accepts the round-robin winner
// CMP   | latched operands are being compared
// RESP  | result presented until rsp_ready
module cmp_share_arb
  import cmp_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = CMP_DEF_DATA_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_eq,
  output logic                      rsp_gt,
  output logic                      rsp_lt
);

  cmp_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     cur_id_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q;
  cmp_res_t            res_q, core_res;
  logic [ID_W-1:0]     grant;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic                any_valid, accept;

  // First valid requester at or above ptr, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] g;
    logic [ID_W-1:0] idx;
    logic            found;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && v[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  assign any_valid = |req_valid;
  assign grant     = rr_pick(req_valid, rr_ptr_q);
  assign accept    = (state_q == IDLE) && any_valid;
  assign rr_ptr_d  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  cmp_core #(.DATA_W(DATA_W)) u_cmp_core (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .res_o (core_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = CMP;
      CMP:                    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant == ID_W'(i));
    end
    rsp_valid = (state_q == RESP);
  end

  // Result flops are loaded only in CMP and cleared on handshake, so they read 0 outside RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
    end else begin
      if (accept) begin
        op_a_q   <= sel_a;
        op_b_q   <= sel_b;
        cur_id_q <= grant;
        rr_ptr_q <= rr_ptr_d;
      end
      if (state_q == CMP)                    res_q <= core_res;
      else if (state_q == RESP && rsp_ready) res_q <= '0;
    end
  end

  assign rsp_id = cur_id_q;
  assign rsp_eq = res_q.eq;
  assign rsp_gt = res_q.gt;
  assign rsp_lt = res_q.lt;

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed self-checking bench for cmp_share_arb (NUM_REQ=4, DATA_W=8).
module tb_cmp_share_arb;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_eq, rsp_gt, rsp_lt;

  int n_checks;
  int n_errors;

  cmp_share_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_eq    (rsp_eq),
    .rsp_gt    (rsp_gt),
    .rsp_lt    (rsp_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
  endtask

  function automatic logic [2:0] flags();
    return {rsp_eq, rsp_gt, rsp_lt};
  endfunction

  // {eq,gt,lt}
  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;

  logic [2:0] exp_sign;
  int         exp_id;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_flags", flags(), 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 2, equal operands
    set_ops(2, 8'h35, 8'h35);
    req_valid = 4'b0100;
    #1;
    check("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    #1;
    check("single_cmp_ready", req_ready, 0);
    check("single_cmp_valid", rsp_valid, 0);
    tick();
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, 2);
    check("single_flags", flags(), F_EQ);
    tick();
    check("single_done_valid", rsp_valid, 0);
    check("single_done_flags", flags(), 0);

    // All four valid from reset: responses 0..3, accepts 3 cycles apart
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_ops(0, 8'd1, 8'd2);
    set_ops(1, 8'd3, 8'd3);
    set_ops(2, 8'd9, 8'd4);
    set_ops(3, 8'h00, 8'hFF);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("all4_ready_%0d", k), req_ready, 32'(1) << k);
      tick();
      req_valid[k] = 1'b0;
      tick();
      check($sformatf("all4_valid_%0d", k), rsp_valid, 1);
      check($sformatf("all4_id_%0d", k), rsp_id, k);
      check($sformatf("all4_flags_%0d", k), flags(),
            (k == 0) ? F_LT : (k == 1) ? F_EQ : (k == 2) ? F_GT : F_LT);
      tick();
    end

    // rr_ptr is 0 after the wrap; serve requester 1 so rr_ptr becomes 2
    set_ops(1, 8'h10, 8'h20);
    set_ops(3, 8'h50, 8'h40);
    req_valid = 4'b0010;
    #1;
    check("pre_fair_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();

    // Fairness and wrap: 1 and 3 continuously valid -> 3,1,3,1
    req_valid = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 0) ? 3 : 1;
      check($sformatf("fair_ready_%0d", k), req_ready, 32'(1) << exp_id);
      tick();
      tick();
      check($sformatf("fair_id_%0d", k), rsp_id, exp_id);
      check($sformatf("fair_flags_%0d", k), flags(), (exp_id == 3) ? F_GT : F_LT);
      tick();
    end
    req_valid = '0;

    // Back-pressure plus signedness on 0x80 vs 0x7F (rr_ptr = 2 -> grant 0)
`ifdef CMP_SIGNED_EN
    exp_sign = F_LT;
`else
    exp_sign = F_GT;
`endif
    rsp_ready = 1'b0;
    set_ops(0, 8'h80, 8'h7F);
    req_valid = 4'b0001;
    #1;
    check("bp_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    tick();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_valid_%0d", c), rsp_valid, 1);
      check($sformatf("bp_id_%0d", c), rsp_id, 0);
      check($sformatf("bp_flags_%0d", c), flags(), exp_sign);
      check($sformatf("bp_req_ready_%0d", c), req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_valid", rsp_valid, 1);
    tick();
    check("bp_after_valid", rsp_valid, 0);
    check("bp_after_flags", flags(), 0);
    check("bp_resume_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    check("bp_next_id", rsp_id, 1);
    check("bp_next_flags", flags(), F_LT);
    tick();

    // Reset mid-CMP: requester 2 accepted (rr_ptr = 2), then reset while in CMP
    set_ops(2, 8'd1, 8'd2);
    req_valid = 4'b0100;
    #1;
    check("mid_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_flags", flags(), 0);
    check("mid_rst_id", rsp_id, 0);
    check("mid_rst_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("mid_no_stale_valid", rsp_valid, 0);
    check("mid_no_stale_flags", flags(), 0);
    req_valid = 4'b1111;
    #1;
    check("mid_ptr_zero", req_ready, 4'b0001);
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmp_share_arb.md
# cmp_share_arb

Round-robin scheduler that shares one registered magnitude comparator among `NUM_REQ` requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants one requester at a time, runs the compare, and returns EQ/GT/LT tagged with the requester index through a response handshake. It sits between the compare clients and the comparator datapath, and is the only path by which clients reach the comparator.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; 2..16.
- `DATA_W`, 8: operand width.
- `ID_W`, `$clog2(NUM_REQ)`: response tag width; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high.
- `req_a` in `NUM_REQ*DATA_W`: operand A; slice i belongs to requester i.
- `req_b` in `NUM_REQ*DATA_W`: operand B; slice i belongs to requester i.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_id` out `ID_W`: index of the requester served.
- `rsp_eq`, `rsp_gt`, `rsp_lt` out 1 each: one-hot compare result; all 0 whenever `rsp_valid`=0.

## Operation
- FSM states:
  - IDLE → CMP on request accept.
  - CMP → RESP unconditionally.
  - RESP → IDLE when `rsp_valid && rsp_ready`.
- Arbitration runs in IDLE only:
  - `grant` = first i with `req_valid[i]`=1, searching from `rr_ptr` upward with wrap.
  - `req_ready[grant]`=1 combinationally; all other bits 0.
  - All `req_ready` are 0 in CMP and RESP, and in IDLE when no request is valid.
- Accept (IDLE, `req_valid[grant]`):
  - Latch `req_a`/`req_b` slices of `grant` into `op_a`/`op_b`.
  - Latch `grant` into `cur_id`.
  - Set `rr_ptr` ← `(grant+1) mod NUM_REQ`.
- CMP: compare `op_a` vs `op_b`. Exactly one of eq/gt/lt is registered into the response flops.
- RESP:
  - `rsp_valid`=1 and the result is held stable until `rsp_ready`.
  - `rsp_id` = `cur_id`.
  - On the handshake: result flags clear, `rsp_valid` falls, and the state returns to IDLE.
- Comparison is unsigned by default; width is exactly `DATA_W`, with no extension.
- Requesters must hold `req_valid` and operands until `req_ready`. The block never depends on a requester dropping `req_valid`.

## Timing
- Reset values:
  - state = IDLE, `rr_ptr` = 0, `cur_id` = 0, `op_a`/`op_b` = 0.
  - `rsp_valid` = 0, `rsp_eq`/`rsp_gt`/`rsp_lt` = 0, `rsp_id` = 0.
  - `req_ready` = 0 (no valid requests during reset).
- Latency: accept on edge N, result computed on edge N+1, `rsp_valid` high from edge N+1 (cycle N+2).
- Minimum issue interval:
  - 3 cycles with `rsp_ready` tied high: accept, CMP, RESP.
  - IDLE follows RESP, so the next accept is in the cycle after the response handshake.
- Back-pressure: `rsp_ready`=0 holds RESP indefinitely, and no new request is accepted.
- Simultaneous requests: only the round-robin winner is accepted. Each other valid requester waits at most `NUM_REQ-1` grants.
- Pointer wrap: grant `NUM_REQ-1` sets `rr_ptr` = 0.
- Reset mid-operation: any in-flight request or response is discarded immediately (asynchronously). No response is ever emitted for it.

## Configuration
- `CMP_SIGNED_EN` defined:
  - Operands are compared as two's-complement `DATA_W`-bit values. For example, with `DATA_W`=8, 0x80 < 0x7F gives `rsp_lt`=1.
- Not defined: unsigned compare, so 0x80 > 0x7F gives `rsp_gt`=1.
- Arbitration, handshakes and timing are identical in both builds.

## Structure
- Package `cmp_share_pkg`:
  - `cmp_state_e` enum: IDLE, CMP, RESP.
  - `cmp_res_t` packed struct: eq, gt, lt.
  - Constant `CMP_DEF_DATA_W` = 8.
- Sub-module `cmp_core`: purely combinational `DATA_W` comparator returning `cmp_res_t`. It is the only place `CMP_SIGNED_EN` is tested.
- Round-robin search is a function local to `cmp_share_arb`.

## Test plan
- Single request: requester 2 sends a=0x35, b=0x35 with `rsp_ready`=1 → `req_ready[2]` high one cycle; two cycles later `rsp_valid`=1, `rsp_id`=2, `rsp_eq`=1.
- All four valid from reset, operand pairs (1,2), (3,3), (9,4), (0,0xFF), `rsp_ready`=1 → responses in order id 0,1,2,3 with lt, eq, gt, lt; each accept 3 cycles apart.
- Fairness and wrap: requesters 1 and 3 continuously valid, `rr_ptr` starting at 2 → grant order 3,1,3,1; no requester starved.
- Back-pressure: `rsp_ready`=0 for 10 cycles during RESP → response held bit-stable, all `req_ready`=0; accept resumes the cycle after handshake.
- Signedness: a=0x80, b=0x7F → `rsp_gt`=1 without `CMP_SIGNED_EN`; `rsp_lt`=1 with it.
- Reset mid-CMP: assert `rst_n`=0 in CMP → all outputs 0 immediately; after release no stale response appears and `rr_ptr`=0.
